exp_arbiter: RTL
================

Name: exp_arbiter

Overview:
- Shares one Exp unit among N_REQ softmax requesters, e.g. one per attention head, in the Tiny LeViT attention datapath.
- Round-robin arbitration picks one requester.
- The block latches that requester's operand, drives the Exp unit's en/i_exp handshake and waits for end_flag.
- It returns o_exp to the requester, tagged with the requester's ID.

Parameters:
- DATA_W, 16, operand/result width; equals 2*att_width from the definition package.
- N_REQ, 4, number of requesters; must be >= 2.
- ID_W, $clog2(N_REQ), width of the response ID.
- TIMEOUT_CYC, 64, watchdog limit in cycles; used only with EXP_TIMEOUT_EN.

Ports:
- clk, input, 1, single clock, rising edge.
- rstn, input, 1, asynchronous active-low reset.
- req_valid, input, N_REQ, per-requester request.
- req_data, input, N_REQ*DATA_W, operands; requester i uses bits [i*DATA_W +: DATA_W].
- req_ready, output, N_REQ, one-hot accept strobe, combinational.
- rsp_valid, output, 1, one-cycle result strobe.
- rsp_id, output, ID_W, requester index for this result.
- rsp_data, output, DATA_W, Exp result.
- rsp_err, output, 1, result aborted by the watchdog.
- exp_en, output, 1, to Exp en.
- exp_in, output, DATA_W, to Exp i_exp.
- exp_end, input, 1, from Exp end_flag.
- exp_out, input, DATA_W, from Exp o_exp; valid while exp_end=1.
- busy, output, 1, FSM not in IDLE.

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE, RR pointer=N_REQ-1, so requester 0 has first priority.
  - exp_en=0, exp_in=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, busy=0.
  - Reset mid-operation aborts silently: no response is issued, and the Exp unit sees en fall immediately.
- FSM states: IDLE -> RUN -> GAP -> IDLE.
- IDLE:
  - Grant g = first i with req_valid[i]=1, searching from ptr+1 upward with wrap-around.
  - req_ready[g]=1 combinationally; all other bits are 0.
  - req_ready is 0 in every state other than IDLE.
  - On the edge: operand <= req_data[g], grant_id <= g, ptr <= g, state <= RUN.
  - With no request, state stays IDLE.
- Requester protocol:
  - Hold req_valid and req_data stable until req_ready is seen.
  - Deassert or issue a new request the following cycle.
  - Dropping req_valid before req_ready is permitted; that request is simply not granted.
- RUN:
  - exp_en=1; exp_in=operand, held stable for the whole RUN.
  - On a sampled exp_end=1: rsp_data <= exp_out, rsp_id <= grant_id, rsp_err <= 0, rsp_valid <= 1, state <= GAP.
- GAP:
  - exp_en=0 for exactly one cycle, which guarantees the Exp unit sees en low between operations.
  - rsp_valid=1 during this cycle only; then state <= IDLE.
- rsp_data and rsp_id hold their last values after rsp_valid falls.
- exp_in holds the operand through GAP and IDLE.
- Latency:
  - Request accepted at edge T0.
  - Exp asserts end_flag after L cycles of en.
  - rsp_valid is high in cycle T0+L+1.
  - Minimum accept-to-accept spacing is L+2 cycles.
- exp_end while in IDLE or GAP is ignored.
- Requests arriving during RUN or GAP wait; no request is lost or reordered within a requester.
- busy=1 in RUN and GAP.

Optional Feature:
- Macro EXP_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in RUN and clears on entry to RUN.
  - If TIMEOUT_CYC cycles elapse without exp_end: rsp_valid=1, rsp_err=1, rsp_data=0, rsp_id=grant_id, state -> GAP (exp_en drops).
  - An exp_end arriving in the same cycle as the timeout wins: normal result, rsp_err=0.
- Undefined:
  - No counter is built; rsp_err is tied to 0.
  - RUN waits indefinitely for exp_end.

Test Plan:
- Bench uses an Exp model with latency L=5 and result = i_exp+100.
1. Single request: req_valid[0]=1, data=10 -> req_ready[0] in the same cycle; exp_en high 5 cycles with exp_in=10; rsp_valid 1 cycle later with rsp_id=0, rsp_data=110; one-cycle exp_en low gap.
2. req_valid=4'b1111 with data 10,20,30,40 held until each ready -> responses in order id 0,1,2,3 with data 110,120,130,140; exp_en low for one cycle between operations.
3. Round-robin wrap: after the last grant went to id 1, req_valid=4'b1001 simultaneously -> id 3 served first, then id 0.
4. Reset mid-operation: rstn=0 in RUN cycle 3 -> exp_en, rsp_valid and busy all 0 immediately; after release, a fresh req_valid[2] is served as in scenario 1 and no stale response appears.
5. Spurious exp_end=1 in IDLE with no requests -> no rsp_valid, busy stays 0.
6. With EXP_TIMEOUT_EN, model never asserts end, TIMEOUT_CYC=64 -> rsp_valid with rsp_err=1, rsp_data=0 after 64 RUN cycles, then IDLE; without the macro, busy stays 1 and rsp_err stays 0.

Source files
------------

// File: rtl/exp_arbiter.sv
// Round-robin arbiter sharing one Exp unit among N_REQ softmax requesters.
// Optional watchdog on the Exp handshake is built when EXP_TIMEOUT_EN is defined.
module exp_arbiter #(
  parameter int DATA_W      = 16,
  parameter int N_REQ       = 4,
  parameter int ID_W        = $clog2(N_REQ),
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_err,
  output logic                    exp_en,
  output logic [DATA_W-1:0]       exp_in,
  input  logic                    exp_end,
  input  logic [DATA_W-1:0]       exp_out,
  output logic                    busy
);

  // Handshake: requester i holds req_valid[i]/data until req_ready[i] is seen;
  // a transfer happens on the rising edge where both are high (IDLE only).
  // rsp_valid is a one-cycle strobe with no back-pressure.

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   grant_id_q;
  logic [DATA_W-1:0] operand_q;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   idx_id;
  logic              found;
  logic              accept;
  logic              done_ok;
  logic              rsp_valid_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [DATA_W-1:0] rsp_data_q;
  int                idx;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    found  = 1'b0;
    grant  = '0;
    idx    = 0;
    idx_id = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx    = (int'(ptr_q) + i) % N_REQ;
      idx_id = ID_W'(idx);
      if (!found && req_valid[idx_id]) begin
        found = 1'b1;
        grant = idx_id;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && found) req_ready[grant] = 1'b1;
  end

`ifdef EXP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt_q;
  logic          timeout_hit;
  logic          done_to;
  logic          rsp_err_q;

  assign timeout_hit = (tcnt_q == TW'(TIMEOUT_CYC - 1));

  // Counts RUN cycles; held at zero elsewhere so each RUN starts fresh.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                tcnt_q <= '0;
    else if (state_q != RUN)  tcnt_q <= '0;
    else                      tcnt_q <= tcnt_q + TW'(1);
  end
`endif

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done_ok = 1'b0;
`ifdef EXP_TIMEOUT_EN
    done_to = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (exp_end) begin
          done_ok = 1'b1;
          state_d = GAP;
        end
`ifdef EXP_TIMEOUT_EN
        else if (timeout_hit) begin
          done_to = 1'b1;
          state_d = GAP;
        end
`endif
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q       <= ID_W'(N_REQ - 1);
      grant_id_q  <= '0;
      operand_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
`ifdef EXP_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      if (accept) begin
        operand_q  <= req_data[int'(grant)*DATA_W +: DATA_W];
        grant_id_q <= grant;
        ptr_q      <= grant;
      end
      if (done_ok) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= exp_out;
        rsp_id_q    <= grant_id_q;
`ifdef EXP_TIMEOUT_EN
        rsp_err_q   <= 1'b0;
`endif
      end
`ifdef EXP_TIMEOUT_EN
      else if (done_to) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= '0;
        rsp_id_q    <= grant_id_q;
        rsp_err_q   <= 1'b1;
      end
`endif
    end
  end

`ifdef EXP_TIMEOUT_EN
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // exp_en derives from state so an async reset drops it at once.
  assign exp_en    = (state_q == RUN);
  assign exp_in    = operand_q;
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule
